// File: rtl/dac_dual_writer.sv
// Paced dual-channel DAC writer: FIFO-buffered tagged samples replayed one per DIV clocks.
// Optional TWOS_COMP_IN_EN: input samples are two's complement, converted to offset binary.
module dac_dual_writer #(
  parameter int DW    = 10,
  parameter int DEPTH = 8,
  parameter int DIV   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            s_data,
  input  logic                     s_chan,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [DW-1:0]            out,
  output logic                     clka,
  output logic                     clkb,
  output logic                     DACWriteA,
  output logic                     DACWriteB,
  input  logic                     underrun_clr,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DIV);

  typedef enum logic [1:0] {IDLE, LOAD, STROBE, HOLD} state_t;

  function automatic logic [DW-1:0] to_dac(input logic [DW-1:0] d);
`ifdef TWOS_COMP_IN_EN
    return {~d[DW-1], d[DW-2:0]};
`else
    return d;
`endif
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            sel_q, sel_d;
  logic [DW-1:0]   out_q, out_d;
  logic            stra_q, stra_d, strb_q, strb_d;
  logic            underrun_q, underrun_d;
  logic [DW:0]     mem_q [DEPTH];
  logic            tick, empty, full, push, pop;
  logic [DW:0]     head;

  assign tick  = (cnt_q == '0);
  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign push  = s_valid & ~full;
  assign pop   = tick & ~empty;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d      = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    sel_d      = pop ? head[DW] : sel_q;
    out_d      = pop ? to_dac(head[DW-1:0]) : out_q;
    // A new underrun takes priority over a simultaneous clear.
    underrun_d = (tick & empty) ? 1'b1 : (underrun_clr ? 1'b0 : underrun_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HOLD: if (tick) state_d = pop ? LOAD : IDLE;
      LOAD:       state_d = STROBE;
      STROBE:     if (cnt_q == CW'(DIV / 2 + 1)) state_d = HOLD;
      default:    state_d = IDLE;
    endcase
    // Strobes are registered from the next state so they track the FSM exactly.
    stra_d = (state_d == STROBE) & ~sel_d;
    strb_d = (state_d == STROBE) &  sel_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      sel_q      <= 1'b0;
      out_q      <= '0;
      stra_q     <= 1'b0;
      strb_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      sel_q      <= sel_d;
      out_q      <= out_d;
      stra_q     <= stra_d;
      strb_q     <= strb_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_chan, s_data};
  end

  assign s_ready   = ~full;
  assign out       = out_q;
  assign clka      = stra_q;
  assign clkb      = strb_q;
  assign DACWriteA = stra_q;
  assign DACWriteB = strb_q;
  assign underrun  = underrun_q;
  assign level     = level_q;

endmodule

// File: tb/tb_dac_dual_writer.sv
// Directed bench for dac_dual_writer (DEPTH=8, DIV=4): vector table plus hand-timed corner sequences.
module tb_dac_dual_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] s_data;
  logic       s_chan;
  logic       s_valid;
  logic       s_ready;
  logic [9:0] out;
  logic       clka, clkb, DACWriteA, DACWriteB;
  logic       underrun_clr;
  logic       underrun;
  logic [3:0] level;

  int errors = 0;
  int checks = 0;

`ifdef TWOS_COMP_IN_EN
  localparam logic [9:0] MSB_FLIP = 10'h200;
`else
  localparam logic [9:0] MSB_FLIP = 10'h000;
`endif

  typedef struct {
    logic [9:0] data;
    logic       chan;
    logic [9:0] exp_out;
    logic       exp_a;
    logic       exp_b;
  } vec_t;

  vec_t vecs [12];

  int   ramp;
  int   ramp_k;
  logic push_done;
  logic saw_full;

  dac_dual_writer #(.DW(10), .DEPTH(8), .DIV(4)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_chan(s_chan), .s_valid(s_valid),
    .s_ready(s_ready), .out(out), .clka(clka), .clkb(clkb),
    .DACWriteA(DACWriteA), .DACWriteB(DACWriteB), .underrun_clr(underrun_clr),
    .underrun(underrun), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sample is accepted.
  task automatic push(input logic [9:0] d, input logic c);
    int n = 0;
    s_data  = d;
    s_chan  = c;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Waits for a strobe, checks setup/strobe/hold; returns at the negedge where strobes are low.
  task automatic expect_slot(input logic [9:0] e, input logic c);
    int n = 0;
    logic [9:0] prev;
    prev = out;
    while (!(clka || clkb) && n < 40) begin
      prev = out;
      @(negedge clk);
      n++;
    end
    if (!(clka || clkb)) begin
      chk("slot_timeout", 32'd1, 32'd0);
      return;
    end
    chk("slot_out", out, e);
    chk("setup_out", prev, e);
    chk("strobe_a", {clka, DACWriteA}, {~c, ~c});
    chk("strobe_b", {clkb, DACWriteB}, {c, c});
    @(negedge clk);
    chk("strobe_2nd", {clka, clkb}, {~c, c});
    @(negedge clk);
    chk("strobe_fall", {clka, clkb}, 2'b00);
    chk("hold_out", out, e);
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = '{data: 10'(i), chan: 1'b0, exp_out: 10'(i), exp_a: 1'b1, exp_b: 1'b0};
    vecs[8]  = '{data: 10'h155, chan: 1'b0, exp_out: 10'h155, exp_a: 1'b1, exp_b: 1'b0};
    vecs[9]  = '{data: 10'h2AA, chan: 1'b1, exp_out: 10'h2AA, exp_a: 1'b0, exp_b: 1'b1};
    vecs[10] = '{data: 10'h155, chan: 1'b0, exp_out: 10'h155, exp_a: 1'b1, exp_b: 1'b0};
    vecs[11] = '{data: 10'h2AA, chan: 1'b1, exp_out: 10'h2AA, exp_a: 1'b0, exp_b: 1'b1};

    reset = 1'b1; s_data = '0; s_chan = 1'b0; s_valid = 1'b0; underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out", out, 10'h000);
    chk("rst_strobes", {clka, clkb, DACWriteA, DACWriteB}, 4'b0000);
    chk("rst_ready", s_ready, 1'b1);
    chk("rst_level", level, 4'd0);
    chk("rst_underrun", underrun, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_tick_underrun", underrun, 1'b1);
    chk("first_tick_strobes", {clka, clkb}, 2'b00);

    // Table: ramp on A, then A/B alternation.
    fork
      begin
        for (int i = 0; i < 12; i++) push(vecs[i].data, vecs[i].chan);
      end
      begin
        for (int i = 0; i < 12; i++) begin
          expect_slot(vecs[i].exp_out ^ MSB_FLIP, vecs[i].chan);
          chk("vec_a_b", {vecs[i].exp_a, vecs[i].exp_b}, {~vecs[i].chan, vecs[i].chan});
        end
      end
    join

    // Continuous valid for 40 clocks: back-pressure and contiguous output.
    ramp = 10'h100; ramp_k = 10'h100; push_done = 1'b0; saw_full = 1'b0;
    fork
      begin
        s_chan = 1'b0;
        for (int i = 0; i < 40; i++) begin
          chk("ready_vs_level", s_ready, (level != 4'd8));
          if (level == 4'd8) saw_full = 1'b1;
          s_data  = 10'(ramp);
          s_valid = 1'b1;
          if (s_ready) ramp = ramp + 1;
          @(negedge clk);
        end
        s_valid = 1'b0;
        push_done = 1'b1;
      end
      begin
        while (!push_done || ramp_k < ramp) begin
          expect_slot(10'(ramp_k) ^ MSB_FLIP, 1'b0);
          ramp_k++;
        end
      end
    join
    chk("saw_full", saw_full, 1'b1);
    chk("ramp_count", ramp_k, ramp);

    // Two samples then starvation; underrun set/clear timing.
    push(10'h0AB, 1'b0);
    push(10'h3C1, 1'b1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("clr_underrun", underrun, 1'b0);
    expect_slot(10'h0AB ^ MSB_FLIP, 1'b0);
    chk("no_underrun_mid", underrun, 1'b0);
    expect_slot(10'h3C1 ^ MSB_FLIP, 1'b1);
    chk("no_early_underrun", underrun, 1'b0);
    @(negedge clk);
    chk("starve_underrun", underrun, 1'b1);
    chk("starve_hold_out", out, 10'h3C1 ^ MSB_FLIP);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("clr_after_pulse", underrun, 1'b0);
    chk("starve_strobes", {clka, clkb}, 2'b00);
    @(negedge clk);
    chk("starve_strobes2", {clka, clkb}, 2'b00);
    @(negedge clk);
    underrun_clr = 1'b1;
    chk("starve_strobes3", {clka, clkb}, 2'b00);
    @(negedge clk);
    underrun_clr = 1'b0;
    chk("clr_vs_new_underrun", underrun, 1'b1);
    chk("starve_hold_out2", out, 10'h3C1 ^ MSB_FLIP);

    // Six pushes from cnt==1 leave level 5 during the first strobe; reset there.
    push(10'h111, 1'b0);
    for (int i = 0; i < 5; i++) push(10'(10'h020 + i), 1'b1);
    chk("pre_rst_strobe", clka, 1'b1);
    chk("pre_rst_level", level, 4'd5);
    chk("pre_rst_out", out, 10'h111 ^ MSB_FLIP);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", {clka, clkb, DACWriteA, DACWriteB}, 4'b0000);
    chk("mid_rst_level", level, 4'd0);
    chk("mid_rst_out", out, 10'h000);
    chk("mid_rst_ready", s_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Sign-boundary samples.
    push(10'h200, 1'b0);
    push(10'h1FF, 1'b1);
`ifdef TWOS_COMP_IN_EN
    expect_slot(10'h000, 1'b0);
    expect_slot(10'h3FF, 1'b1);
`else
    expect_slot(10'h200, 1'b0);
    expect_slot(10'h1FF, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
